uart_program_loader: RTL and testbench
======================================

# uart_program_loader

SoC-side receiver for the UART firmware download path. While `programmer_mode_i` is high, it deserializes 8N1 bytes from the programmer UART line and packs them little-endian into 32-bit words. Each word is written sequentially into instruction memory starting at word address 0, and the CPU is held in reset until the download completes. It sits between the board `rx` pin and the instruction-memory write port in the SoC wrapper.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 50_000_000, core clock frequency.
- `BAUD_RATE`, 9600, UART bit rate; CPB = CLK_FREQ_HZ/BAUD_RATE, integer-truncated (5208 at defaults).
- `ADDR_WIDTH`, 12, instruction-memory word-address width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `programmer_mode_i` in 1: level; high = download session active.
- `uart_rx_i` in 1: asynchronous UART line, idle high.
- `mem_we_o` out 1: write request, held until accepted.
- `mem_ready_i` in 1: memory accepts the write on a cycle where `mem_we_o && mem_ready_i`.
- `mem_addr_o` out ADDR_WIDTH: word address of the pending write.
- `mem_wdata_o` out 32: word data.
- `core_reset_o` out 1: holds the CPU in reset.
- `busy_o` out 1: session active or a write is still pending.
- `frame_err_o` out 1: one-cycle pulse on a bad stop bit.
- `overflow_o` out 1: sticky; a word was dropped because the previous write was still pending.
- `checksum_o` out 32: running sum of accepted words (see Configuration).

## Operation
- `uart_rx_i` passes through a 2-flop synchronizer; both flops reset to 1.
- RX FSM:
  - IDLE → START when the synchronized line is low.
  - START: wait CPB/2 cycles, then resample. If high, the start was a glitch and the FSM returns to IDLE. If low, → DATA.
  - DATA: 8 bits, LSB first, one sample every CPB cycles.
  - STOP: sample once after CPB cycles. High → `byte_valid` for one cycle. Low → `frame_err_o` pulse and the byte is dropped. Either way → IDLE.
- Bytes are accepted only while `programmer_mode_i` is high; otherwise the RX FSM runs but its output is ignored.
- Word assembly: a 2-bit `byte_idx` places byte k at bits [8k+7:8k]. When the 4th byte arrives, the word moves to the single holding register and `mem_we_o` rises; `byte_idx` returns to 0.
- If a word completes while `mem_we_o` is still high and unaccepted, that new word is dropped, `overflow_o` is set, and the pending write is unaffected.
- Address counter:
  - Cleared to 0 on the rising edge of `programmer_mode_i`.
  - Increments on every accepted write.
  - Wraps from 2^ADDR_WIDTH−1 to 0.
- Session FSM:
  - OFF → LOAD on the rising edge of `programmer_mode_i`.
  - LOAD → FLUSH on the falling edge of `programmer_mode_i`.
  - FLUSH: if `byte_idx` ≠ 0, the partial word is zero-padded in the upper bytes and written; `byte_idx` is cleared. The FSM waits for every pending write to be accepted, then → OFF.
  - A byte still mid-reception when mode falls is discarded.
- `core_reset_o` = 1 in LOAD and FLUSH, 0 in OFF.
- `busy_o` = (state ≠ OFF) || `mem_we_o`.

## Timing
- Reset values:
  - Outputs: `mem_we_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0, `core_reset_o` 0, `busy_o` 0, `frame_err_o` 0, `overflow_o` 0, `checksum_o` 0.
  - Internal: FSMs to IDLE/OFF, `byte_idx` 0.
- Reset mid-byte or mid-write drops all state; there is no write after reset.
- Sample points, counted from the first cycle the synchronized line reads low:
  - start check at CPB/2;
  - data bit k at CPB/2 + (k+1)·CPB;
  - stop bit at CPB/2 + 9·CPB.
- `byte_valid` and `frame_err_o` assert the cycle after the stop sample.
- `mem_we_o` rises the cycle after the 4th `byte_valid`.
- On an accepting cycle, `mem_addr_o` increments and `mem_we_o` falls on the next edge unless a new word is loaded in that same cycle. A write accepted and a word completing in the same cycle is legal: it loads the new word with no overflow.
- `core_reset_o` falls the cycle after the last write is accepted, or 1 cycle after the mode falls if nothing is pending.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - `checksum_o` accumulates each accepted `mem_wdata_o`, modulo 2^32.
  - It clears on the rising edge of `programmer_mode_i`.
- Not defined: `checksum_o` is constant 0 and the adder is not synthesized.

## Test plan
- Reset, then idle for 100 cycles → all outputs at their reset values; `rst` asserted mid-byte → no write and `byte_idx` 0 afterwards.
- Mode high, bytes 13 00 00 00 93 00 10 00 at 9600 baud → writes (addr 0, 0x00000013) then (addr 1, 0x00100093); with the macro defined, `checksum_o` = 0x001000A6.
- Byte 0x55 sent with its stop bit driven low → one `frame_err_o` pulse, no byte accepted, `byte_idx` unchanged.
- `mem_ready_i` held low across two complete words → first word stays pending, `overflow_o` = 1, the second word is never written.
- Bytes AA BB, then mode falls → write (addr 0, 0x0000BBAA); `core_reset_o` falls the cycle after acceptance.
- 1-cycle low glitch on `uart_rx_i` → no byte and no frame error.

Source files
------------

// File: rtl/uart_program_loader.sv
// uart_program_loader
//
// Receives 8N1 bytes from the programmer UART while programmer_mode_i is high,
// packs them little-endian into 32-bit words and writes them sequentially into
// instruction memory from word address 0. The CPU is held in reset for the
// whole download session, including the final flush of a partial word.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   programmer_mode_i   level, high = download session active
//   uart_rx_i           asynchronous UART line, idle high
//   mem_we_o            write request, held until mem_ready_i accepts it
//   mem_ready_i         write accepted on a cycle with mem_we_o && mem_ready_i
//   mem_addr_o          word address of the pending write
//   mem_wdata_o         word data of the pending write
//   core_reset_o        holds the CPU in reset while a session is live
//   busy_o              session live or a write still pending
//   frame_err_o         one-cycle pulse on a bad stop bit
//   overflow_o          sticky, a word was dropped behind a pending write
//   checksum_o          running sum of accepted words
//
// Build option: define PROG_LOADER_CHECKSUM_EN to enable the checksum adder;
// without it checksum_o is tied to zero.
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a low level
//   RX_START | half-bit wait, then confirm the start bit
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling the stop bit
//
// Session FSM
//   state    | meaning
//   SS_OFF   | no download, CPU released
//   SS_LOAD  | download active, bytes accepted
//   SS_FLUSH | mode dropped, writing partial word and draining the pending write

module uart_program_loader #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  programmer_mode_i,
  input  logic                  uart_rx_i,
  output logic                  mem_we_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  core_reset_o,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overflow_o,
  output logic [31:0]           checksum_o
);

  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int TW  = $clog2(CPB + 1);
  localparam logic [TW-1:0] TIMER_FULL = TW'(CPB - 1);
  localparam logic [TW-1:0] TIMER_HALF = TW'(CPB / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] SS_OFF   = 2'd0;
  localparam logic [1:0] SS_LOAD  = 2'd1;
  localparam logic [1:0] SS_FLUSH = 2'd2;

  logic          rx_meta, rx_sync;
  logic [1:0]    rx_state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          byte_valid;

  logic [1:0]    sess_state;
  logic          mode_q;
  logic [1:0]    byte_idx;
  logic [31:0]   word_buf;

  logic          mode_rise, byte_take, accept, can_load;
  logic          full_done, flush_load, word_load;
  logic [31:0]   word_next;

  // Timer counts down to zero; a sample is taken on the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_state    <= RX_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      byte_valid  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_meta     <= uart_rx_i;
      rx_sync     <= rx_meta;
      byte_valid  <= 1'b0;
      frame_err_o <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            timer    <= TIMER_HALF;
          end
        end
        RX_START: begin
          if (timer == '0) begin
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              timer    <= TIMER_FULL;
              bit_cnt  <= '0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RX_DATA: begin
          if (timer == '0) begin
            shift <= {rx_sync, shift[7:1]};
            timer <= TIMER_FULL;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          if (timer == '0) begin
            rx_state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else frame_err_o <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
      endcase
    end
  end

  assign mode_rise  = programmer_mode_i && !mode_q;
  assign byte_take  = byte_valid && programmer_mode_i && (sess_state == SS_LOAD);
  assign accept     = mem_we_o && mem_ready_i;
  // The holding register is free if empty or being accepted this cycle.
  assign can_load   = !mem_we_o || mem_ready_i;
  assign full_done  = byte_take && (byte_idx == 2'd3);
  // A partial word waits for the holding register instead of overflowing.
  assign flush_load = (sess_state == SS_FLUSH) && (byte_idx != 2'd0) && can_load;
  assign word_load  = (full_done && can_load) || flush_load;
  // word_buf upper bytes are kept zero, which gives the flush padding for free.
  assign word_next  = full_done ? {shift, word_buf[23:0]} : word_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b0;
      sess_state  <= SS_OFF;
      byte_idx    <= '0;
      word_buf    <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      overflow_o  <= 1'b0;
    end else begin
      mode_q <= programmer_mode_i;

      if (accept) mem_we_o <= 1'b0;
      if (word_load) begin
        mem_we_o    <= 1'b1;
        mem_wdata_o <= word_next;
      end
      if (full_done && !can_load) overflow_o <= 1'b1;

      if (mode_rise) mem_addr_o <= '0;
      else if (accept) mem_addr_o <= mem_addr_o + 1'b1;

      if (mode_rise) begin
        byte_idx <= '0;
        word_buf <= '0;
      end else if (byte_take) begin
        if (byte_idx == 2'd3) begin
          byte_idx <= '0;
          word_buf <= '0;
        end else begin
          word_buf[{byte_idx, 3'b000} +: 8] <= shift;
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (flush_load) begin
        byte_idx <= '0;
        word_buf <= '0;
      end

      case (sess_state)
        SS_OFF:   if (mode_rise) sess_state <= SS_LOAD;
        SS_LOAD: begin
          // Nothing left to write: release the CPU without a flush cycle.
          if (!programmer_mode_i)
            sess_state <= (byte_idx == 2'd0 && can_load) ? SS_OFF : SS_FLUSH;
        end
        SS_FLUSH: if (byte_idx == 2'd0 && can_load) sess_state <= SS_OFF;
        default:  sess_state <= SS_OFF;
      endcase
    end
  end

  assign core_reset_o = (sess_state != SS_OFF);
  assign busy_o       = core_reset_o || mem_we_o;

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) checksum_o <= '0;
    else if (mode_rise) checksum_o <= '0;
    else if (accept) checksum_o <= checksum_o + mem_wdata_o;
  end
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
`timescale 1ns/1ps
module tb_uart_program_loader;
  localparam int CLK_HZ = 160_000;
  localparam int BAUD   = 10_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int AW     = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          rx = 1'b1;
  logic          ready = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_reset, busy, frame_err, overflow;
  logic [31:0]   checksum;

  int checks = 0;
  int failures = 0;
  int ready_mode = 1;

  int            cyc = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];
  int            last_acc_cyc, core_fall_cyc, mode_fall_cyc, fe_cnt;
  logic          core_q = 1'b0;
  logic          mode_q = 1'b0;

  logic [7:0]    sent_bytes[$];
  logic [31:0]   exp_words[$];

  uart_program_loader #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .programmer_mode_i(mode), .uart_rx_i(rx),
    .mem_we_o(mem_we), .mem_ready_i(ready), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .core_reset_o(core_reset), .busy_o(busy),
    .frame_err_o(frame_err), .overflow_o(overflow), .checksum_o(checksum)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we && ready) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      last_acc_cyc = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (core_q && !core_reset) core_fall_cyc = cyc;
    if (mode_q && !mode) mode_fall_cyc = cyc;
    core_q = core_reset;
    mode_q = mode;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_monitor();
    wr_addr_q.delete();
    wr_data_q.delete();
    sent_bytes.delete();
    fe_cnt = 0;
    last_acc_cyc = -1;
    core_fall_cyc = -1;
    mode_fall_cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mode = 1'b0; rx = 1'b1; ready_mode = 1;
    wait_cyc(3);
    rst = 1'b0;
    clear_monitor();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop;
    wait_cyc(CPB);
    rx = 1'b1;
    wait_cyc(2 * CPB);
    if (stop) sent_bytes.push_back(b);
  endtask

  task automatic end_session(output bit ok);
    ok = 1'b0;
    mode = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      wait_cyc(1);
      if (!core_reset && !mem_we) begin
        ok = 1'b1;
        break;
      end
    end
    wait_cyc(2);
  endtask

  // Little-endian packing of the accepted byte stream, partial word zero-padded.
  function automatic void build_model();
    logic [31:0] w = '0;
    exp_words.delete();
    for (int i = 0; i < sent_bytes.size(); i++) begin
      w = w | (32'(sent_bytes[i]) << (8 * (i % 4)));
      if (i % 4 == 3) begin
        exp_words.push_back(w);
        w = '0;
      end
    end
    if (sent_bytes.size() % 4 != 0) exp_words.push_back(w);
  endfunction

  task automatic test_reset();
    bit ok;
    do_reset();
    wait_cyc(100);
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL rst_core_reset got=%b exp=0", core_reset); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0 || fe_cnt != 0) begin failures++; $display("FAIL rst_frame_err got=%b cnt=%0d exp=0", frame_err, fe_cnt); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    checks++; if (checksum !== 32'h0) begin failures++; $display("FAIL rst_checksum got=%h exp=0", checksum); end

    // Three bytes plus a partial fourth, then reset: nothing may be written.
    mode = 1'b1;
    wait_cyc(5);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    rx = 1'b0;
    wait_cyc(3 * CPB);
    rst = 1'b1; rx = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2 * CPB);
    checks++; if (wr_data_q.size() != 0) begin failures++; $display("FAIL rst_mid_no_write got=%0d exp=0", wr_data_q.size()); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mid_mem_we got=%b exp=0", mem_we); end
    sent_bytes.delete();
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    end_session(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_mid_session_end timeout"); end
    checks++; if (wr_data_q.size() != 1) begin failures++; $display("FAIL rst_mid_count got=%0d exp=1", wr_data_q.size()); end
    else begin
      checks++; if (wr_data_q[0] !== 32'h04030201) begin failures++; $display("FAIL rst_mid_word got=%h exp=04030201", wr_data_q[0]); end
      checks++; if (wr_addr_q[0] !== '0) begin failures++; $display("FAIL rst_mid_addr got=%0h exp=0", wr_addr_q[0]); end
    end
  endtask

  task automatic test_program();
    bit ok;
    logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [31:0] exp_ck;
    do_reset();
    mode = 1'b1;
    wait_cyc(5);
    foreach (prog[i]) send_byte(prog[i], 1'b1);
    end_session(ok);
    checks++; if (!ok) begin failures++; $display("FAIL prog_session_end timeout"); end
    checks++; if (wr_data_q.size() != 2) begin failures++; $display("FAIL prog_count got=%0d exp=2", wr_data_q.size()); end
    else begin
      checks++; if (wr_data_q[0] !== 32'h00000013 || wr_addr_q[0] !== 3'd0) begin failures++; $display("FAIL prog_w0 got=%0h:%h exp=0:00000013", wr_addr_q[0], wr_data_q[0]); end
      checks++; if (wr_data_q[1] !== 32'h00100093 || wr_addr_q[1] !== 3'd1) begin failures++; $display("FAIL prog_w1 got=%0h:%h exp=1:00100093", wr_addr_q[1], wr_data_q[1]); end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    exp_ck = 32'h001000A6;
`else
    exp_ck = 32'h0;
`endif
    checks++; if (checksum !== exp_ck) begin failures++; $display("FAIL prog_checksum got=%h exp=%h", checksum, exp_ck); end
  endtask

  task automatic test_frame_error();
    bit ok;
    do_reset();
    mode = 1'b1;
    wait_cyc(5);
    send_byte(8'h11, 1'b1);
    send_byte(8'h55, 1'b0);
    checks++; if (fe_cnt != 1) begin failures++; $display("FAIL fe_pulse got=%0d cycles exp=1", fe_cnt); end
    send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    end_session(ok);
    checks++; if (!ok) begin failures++; $display("FAIL fe_session_end timeout"); end
    checks++; if (wr_data_q.size() != 1) begin failures++; $display("FAIL fe_count got=%0d exp=1", wr_data_q.size()); end
    else begin
      checks++; if (wr_data_q[0] !== 32'h44332211) begin failures++; $display("FAIL fe_word got=%h exp=44332211", wr_data_q[0]); end
    end
    checks++; if (fe_cnt != 1) begin failures++; $display("FAIL fe_total got=%0d exp=1", fe_cnt); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    ready_mode = 0;
    mode = 1'b1;
    wait_cyc(5);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
    build_model();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (mem_we !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL ovf_pending we=%b busy=%b exp=1", mem_we, busy); end
    checks++; if (mem_wdata !== exp_words[0] || mem_addr !== '0) begin failures++; $display("FAIL ovf_hold got=%0h:%h exp=0:%h", mem_addr, mem_wdata, exp_words[0]); end
    ready_mode = 1;
    end_session(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_session_end timeout"); end
    checks++; if (wr_data_q.size() != 1) begin failures++; $display("FAIL ovf_count got=%0d exp=1", wr_data_q.size()); end
    else begin
      checks++; if (wr_data_q[0] !== exp_words[0]) begin failures++; $display("FAIL ovf_word got=%h exp=%h", wr_data_q[0], exp_words[0]); end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_flush();
    bit ok;
    do_reset();
    mode = 1'b1;
    wait_cyc(5);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    end_session(ok);
    checks++; if (!ok) begin failures++; $display("FAIL flush_session_end timeout"); end
    checks++; if (wr_data_q.size() != 1) begin failures++; $display("FAIL flush_count got=%0d exp=1", wr_data_q.size()); end
    else begin
      checks++; if (wr_data_q[0] !== 32'h0000BBAA || wr_addr_q[0] !== '0) begin failures++; $display("FAIL flush_word got=%0h:%h exp=0:0000bbaa", wr_addr_q[0], wr_data_q[0]); end
    end
    checks++; if (core_fall_cyc - last_acc_cyc != 1) begin failures++; $display("FAIL flush_core_release got=%0d cycles exp=1", core_fall_cyc - last_acc_cyc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end

    // Empty session: the CPU is released one cycle after mode falls.
    mode = 1'b1;
    wait_cyc(10);
    checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL empty_core_hold got=%b exp=1", core_reset); end
    end_session(ok);
    checks++; if (!ok || core_fall_cyc - mode_fall_cyc != 1) begin failures++; $display("FAIL empty_core_release got=%0d cycles exp=1", core_fall_cyc - mode_fall_cyc); end
  endtask

  task automatic test_glitch();
    bit ok;
    do_reset();
    mode = 1'b1;
    wait_cyc(10);
    rx = 1'b0;
    wait_cyc(1);
    rx = 1'b1;
    wait_cyc(3 * CPB);
    checks++; if (fe_cnt != 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt); end
    checks++; if (mem_we !== 1'b0 || wr_data_q.size() != 0) begin failures++; $display("FAIL glitch_write we=%b n=%0d exp=0", mem_we, wr_data_q.size()); end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    build_model();
    end_session(ok);
    checks++; if (!ok) begin failures++; $display("FAIL glitch_session_end timeout"); end
    checks++; if (wr_data_q.size() != 1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", wr_data_q.size()); end
    else begin
      checks++; if (wr_data_q[0] !== exp_words[0]) begin failures++; $display("FAIL glitch_word got=%h exp=%h", wr_data_q[0], exp_words[0]); end
    end
  endtask

  task automatic test_random_wrap();
    bit ok;
    logic [31:0] exp_ck;
    do_reset();
    ready_mode = 2;
    mode = 1'b1;
    wait_cyc(5);
    for (int i = 0; i < 38; i++) send_byte(8'($urandom), 1'b1);
    end_session(ok);
    ready_mode = 1;
    build_model();
    exp_ck = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
    foreach (exp_words[i]) exp_ck = exp_ck + exp_words[i];
`endif
    checks++; if (!ok) begin failures++; $display("FAIL rand_session_end timeout"); end
    checks++; if (wr_data_q.size() != exp_words.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", wr_data_q.size(), exp_words.size()); end
    for (int i = 0; i < exp_words.size() && i < wr_data_q.size(); i++) begin
      checks++; if (wr_data_q[i] !== exp_words[i]) begin failures++; $display("FAIL rand_word[%0d] got=%h exp=%h", i, wr_data_q[i], exp_words[i]); end
      checks++; if (wr_addr_q[i] !== AW'(i)) begin failures++; $display("FAIL rand_addr[%0d] got=%0d exp=%0d", i, wr_addr_q[i], AW'(i)); end
    end
    checks++; if (checksum !== exp_ck) begin failures++; $display("FAIL rand_checksum got=%h exp=%h", checksum, exp_ck); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rand_overflow got=%b exp=0", overflow); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_program();
    test_frame_error();
    test_overflow();
    test_flush();
    test_glitch();
    test_random_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
